button_event_detector: RTL and testbench
========================================

Name: button_event_detector

Overview:
- Conditions one raw push-button input for the stopwatch and display datapath, which sits downstream and consumes its pulses. Used once per button (en, lap).
- Synchronises and debounces the raw level.
- Classifies each press as short or long, and emits single-cycle event pulses in the `clk` domain.
- Replaces ad-hoc divided-clock one-pulse and three-pulse logic: everything runs on `clk` using a tick enable, with no derived clocks.

Parameters:
- TICK_DIV, 100000: `clk` cycles per debounce/hold tick (1 ms at 100 MHz). Must be >= 2.
- DEBOUNCE_TICKS, 10: consecutive ticks the synchronised input must differ from `btn_level` before `btn_level` flips. Must be >= 1.
- LONG_TICKS, 1000: ticks a debounced press must last to count as a long press. Must be >= 2.
- REPEAT_TICKS, 200: auto-repeat interval in ticks. Used only with BTN_REPEAT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_in  input  1  raw asynchronous button level, active-high
- btn_level  output  1  debounced button level
- press_pulse  output  1  one-cycle pulse on every debounced press
- short_pulse  output  1  one-cycle pulse on release of a press shorter than LONG_TICKS
- long_pulse  output  1  one-cycle pulse when a press reaches LONG_TICKS
- held  output  1  high while the current press has been classified long

Behaviour:
- Reset (synchronous, active-high; one clock, `clk`):
  - All outputs, both synchroniser flops, the tick counter, the debounce counter and the hold counter clear to 0.
  - FSM goes to IDLE.
  - Reset has priority over every other event, including in the middle of a press.
- Synchroniser: two flops, `btn_in` -> s1 -> s2. Only s2 is used downstream.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - `tick` is high for one cycle when the counter equals TICK_DIV-1.
  - Runs freely; it is not restarted by button activity.
- Debounce:
  - deb_cnt clears in any cycle where s2 == `btn_level`.
  - On a tick with s2 != `btn_level`, deb_cnt increments.
  - On the tick where the incremented value reaches DEBOUNCE_TICKS, `btn_level` <= s2 and deb_cnt <= 0.
  - Any glitch shorter than DEBOUNCE_TICKS ticks has no effect on `btn_level`.
- FSM (registered): states IDLE, PRESSED, LONG. "rise" and "fall" refer to the registered `btn_level` changing, sampled in the cycle after the change.
  - IDLE, on rise: -> PRESSED, `press_pulse` = 1 for one cycle, hold_cnt <= 0.
  - PRESSED, each tick while no fall: hold_cnt increments.
  - PRESSED, when hold_cnt == LONG_TICKS-1 on a tick: -> LONG, `long_pulse` = 1 for one cycle, `held` <= 1.
  - PRESSED, on fall: -> IDLE, `short_pulse` = 1 for one cycle.
  - PRESSED, fall and long threshold in the same cycle: release wins. Only `short_pulse` fires; `long_pulse` does not.
  - LONG, on fall: -> IDLE, `held` <= 0, no pulse.
- Pulse rules:
  - Pulses never coincide, except `press_pulse`/`long_pulse` under the optional feature.
  - Each event pulse is exactly one `clk` cycle wide.
- Latency from a clean `btn_in` edge to `btn_level`: 2 cycles of synchroniser, then the DEBOUNCE_TICKS-th tick after s2 changes (tick-phase dependent, between (DEBOUNCE_TICKS-1)·TICK_DIV+1 and DEBOUNCE_TICKS·TICK_DIV cycles).
- `press_pulse`, `short_pulse` and `long_pulse` are registered: they fire 1 cycle after the `btn_level` change or tick that causes them.
- Counter widths: sized by $clog2 of each parameter. hold_cnt never exceeds LONG_TICKS-1.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - In LONG, a repeat counter increments on each tick.
  - Every REPEAT_TICKS ticks the block re-asserts `long_pulse` and `press_pulse` together for one cycle, then the counter clears.
  - The repeat counter clears on entry to LONG and on reset.
  - Release stops repeats immediately, even on the same tick.
- Undefined: LONG emits nothing further until release; no repeat counter logic is generated.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2):
- Reset with `btn_in`=1 throughout -> all outputs 0 during reset. After deassert, `btn_level` rises within 2+12 cycles, then one `press_pulse`.
- Bounce: `btn_in` toggles every 5 cycles for 40 cycles, then stays 1 -> `btn_level` stays 0 during the bounce. Exactly one `press_pulse`, with `btn_level` rising 9–12 cycles (3rd tick) after the final s2 edge.
- Short press: stable high for 4 ticks after `btn_level` rises, then low -> `press_pulse`=1 once. `short_pulse`=1 once after the release debounce. `long_pulse` and `held` stay 0.
- Long press: high for 20 ticks, then low -> `long_pulse`=1 exactly once, 8 ticks after the FSM leaves IDLE. `held`=1 until the debounced fall. No `short_pulse`.
- Reset mid-press: assert `reset` for 1 cycle while in LONG with `btn_in` held 1 -> `held`, `btn_level` and all pulses go to 0, FSM IDLE. After re-debounce, `btn_level` rises and `press_pulse` fires again.
- BTN_REPEAT_EN defined, hold for 14 ticks -> `long_pulse` at tick 8, then `long_pulse`+`press_pulse` at ticks 10 and 12 (and 14 if release debounce is not yet complete). None after the fall.

Source files
------------

// File: rtl/button_event_detector.sv
// Synchronises, debounces and classifies one push-button into single-cycle press/short/long pulses on clk.
// Defining BTN_REPEAT_EN adds auto-repeat of long_pulse/press_pulse every REPEAT_TICKS ticks while held.
module button_event_detector #(
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic held
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int HW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic          s1_q, s2_q;
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [DW-1:0] deb_cnt_q;
    logic          level_q, level_prev_q;
    logic          rise, fall;
    logic          long_hit;
    logic          rep_hit;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          press_q, press_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          held_q, held_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Any cycle where s2 agrees with the current level restarts the debounce window.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
        end else if (s2_q == level_q) begin
            deb_cnt_q <= '0;
        end else if (tick) begin
            if (deb_cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                level_q   <= s2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level_q;
        end
    end

    assign rise     = level_q & ~level_prev_q;
    assign fall     = ~level_q & level_prev_q;
    // Release outranks the long threshold when both land in the same cycle.
    assign long_hit = (state_q == PRESSED) && !fall && tick &&
                      (hold_cnt_q == HW'(LONG_TICKS - 1));

`ifdef BTN_REPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    assign rep_hit = (state_q == LONG) && !fall && tick &&
                     (rep_cnt_q == RW'(REPEAT_TICKS - 1));

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        if (state_q != LONG || fall) begin
            rep_cnt_d = '0;
        end else if (tick) begin
            rep_cnt_d = rep_hit ? '0 : rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    // REPEAT_TICKS only matters with auto-repeat; this folds to constant 0.
    assign rep_hit = (REPEAT_TICKS < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            short_q    <= short_d;
            long_q     <= long_d;
            held_q     <= held_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (long_hit) begin
                    state_d = LONG;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d = ((state_q == IDLE) && rise) || rep_hit;
        short_d = (state_q == PRESSED) && fall;
        long_d  = long_hit || rep_hit;
        held_d  = (state_d == LONG);
    end

    assign btn_level   = level_q;
    assign press_pulse = press_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign held        = held_q;
endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector with TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2.
module tb_button_event_detector;
    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level, press_pulse, short_pulse, long_pulse, held;

    int checks = 0;
    int errors = 0;

    int press_cnt = 0, short_cnt = 0, long_cnt = 0, held_cyc = 0;
    int overlap_err = 0, width_err = 0;
    logic prev_p = 1'b0, prev_s = 1'b0, prev_l = 1'b0;

    button_event_detector #(
        .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(8), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
        .press_pulse(press_pulse), .short_pulse(short_pulse),
        .long_pulse(long_pulse), .held(held)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        press_cnt <= press_cnt + (press_pulse ? 1 : 0);
        short_cnt <= short_cnt + (short_pulse ? 1 : 0);
        long_cnt  <= long_cnt + (long_pulse ? 1 : 0);
        held_cyc  <= held_cyc + (held ? 1 : 0);
        if (short_pulse && (press_pulse || long_pulse))
            overlap_err <= overlap_err + 1;
`ifndef BTN_REPEAT_EN
        else if (press_pulse && long_pulse)
            overlap_err <= overlap_err + 1;
`endif
        if ((press_pulse && prev_p) || (short_pulse && prev_s) || (long_pulse && prev_l))
            width_err <= width_err + 1;
        prev_p <= press_pulse;
        prev_s <= short_pulse;
        prev_l <= long_pulse;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_level(input logic v, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            cyc(1);
            if (btn_level === v) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic int outs();
        return int'({btn_level, press_pulse, short_pulse, long_pulse, held});
    endfunction

    initial begin
        int n;
        int p0, s0, l0, h0;
        int exp_rep;
        logic bounce_bad;

        reset  = 1'b1;
        btn_in = 1'b1;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            check("reset_outs", outs(), 0);
            cyc(1);
        end
        reset = 1'b0;

        // Power-up with button already held, then a quick release.
        wait_level(1'b1, 20, n);
        check("rst_rise_latency", int'(n >= 1 && n <= 14), 1);
        cyc(1);
        check("rst_press_pulse", int'(press_pulse), 1);
        cyc(1);
        check("rst_press_one_cycle", int'(press_pulse), 0);
        btn_in = 1'b0;
        wait_level(1'b0, 20, n);
        cyc(1);
        check("rst_short_pulse", int'(short_pulse), 1);

        // Bounce: 5-cycle toggles never accumulate three ticks.
        p0 = press_cnt;
        bounce_bad = 1'b0;
        for (int seg = 0; seg < 8; seg++) begin
            btn_in = (seg % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                cyc(1);
                if (btn_level !== 1'b0) bounce_bad = 1'b1;
            end
        end
        check("bounce_level_low", int'(bounce_bad), 0);
        btn_in = 1'b1;
        wait_level(1'b1, 20, n);
        check("bounce_rise_latency", int'(n >= 11 && n <= 14), 1);
        cyc(1);

        // Short press: four ticks high after the debounced rise, then release.
        s0 = short_cnt;
        l0 = long_cnt;
        h0 = held_cyc;
        cyc(15);
        btn_in = 1'b0;
        wait_level(1'b0, 20, n);
        cyc(1);
        check("short_pulse_at_fall", int'(short_pulse), 1);
        cyc(2);
        check("short_press_count", press_cnt - p0, 1);
        check("short_short_count", short_cnt - s0, 1);
        check("short_long_count", long_cnt - l0, 0);
        check("short_held_cycles", held_cyc - h0, 0);

        // Long press: long_pulse 32 cycles after the debounced rise.
        p0 = press_cnt;
        s0 = short_cnt;
        l0 = long_cnt;
        btn_in = 1'b1;
        wait_level(1'b1, 20, n);
        cyc(1);
        check("long_press_pulse", int'(press_pulse), 1);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (long_pulse === 1'b1) begin
                n = i;
                break;
            end
        end
        check("long_pulse_delay", n, 31);
        cyc(1);
        check("long_held_after", int'({long_pulse, held}), 1);
        cyc(47);
        btn_in = 1'b0;
        wait_level(1'b0, 20, n);
        check("long_fall_latency", int'(n >= 11 && n <= 14), 1);
        check("long_held_at_fall", int'(held), 1);
        cyc(1);
        check("long_held_cleared", int'(held), 0);
        cyc(2);
`ifdef BTN_REPEAT_EN
        exp_rep = 7;
`else
        exp_rep = 0;
`endif
        check("long_long_count", long_cnt - l0, 1 + exp_rep);
        check("long_press_count", press_cnt - p0, 1 + exp_rep);
        check("long_short_count", short_cnt - s0, 0);

        // Reset while in LONG, button still held.
        btn_in = 1'b1;
        n = -1;
        for (int i = 1; i <= 80; i++) begin
            cyc(1);
            if (held === 1'b1) begin
                n = i;
                break;
            end
        end
        check("mid_reached_long", int'(n > 0), 1);
        reset = 1'b1;
        cyc(1);
        check("mid_reset_outs", outs(), 0);
        reset = 1'b0;
        s0 = short_cnt;
        wait_level(1'b1, 20, n);
        check("mid_rise_latency", int'(n >= 1 && n <= 14), 1);
        cyc(1);
        check("mid_press_pulse", int'(press_pulse), 1);
        btn_in = 1'b0;
        wait_level(1'b0, 20, n);
        cyc(3);
        check("mid_short_count", short_cnt - s0, 1);

        check("pulse_overlap", overlap_err, 0);
        check("pulse_width", width_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
